cpu_mem_dp: RTL and testbench

CPU_MEM_DP -- requirements
Module: cpu_mem_dp

---
 rtl/cpu_mem_dp.sv | 164 ++++++++++++++++
 tb/tb_cpu_mem_dp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_dp.sv
// cpu_mem_dp: one-clock dual-port RAM. Port 0 reads and writes (byte-masked), port 1 only reads.
// Every request is registered on the first edge and reaches the array on the next edge. After
// reset the array can be zeroed one word per cycle, and requests are dropped while that runs.
//
// Ports:
//   clk0, rst0_n          clock (posedge), asynchronous active-low reset
//   csb0, web0            port 0 chip select / write enable, both active low
//   wmask0, addr0, din0   port 0 byte write mask, address, write data
//   dout0, dvalid0        port 0 registered read data and its one-cycle valid pulse
//   csb1, addr1           port 1 chip select (active low) and address
//   dout1, dvalid1        port 1 registered read data and its one-cycle valid pulse
//   busy                  high while the clear sequence runs
module cpu_mem_dp #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RAM_DEPTH      = 256,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    dvalid0,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic                    dvalid1,
  output logic                    busy
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  // One extra bit so that RAM_DEPTH == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_cnt, w_cnt_nxt;

  // Request capture registers.
  logic                    r_csb0, r_web0, r_csb1;
  logic [NB-1:0]           r_wmask0;
  logic [ADDR_WIDTH-1:0]   r_addr0, r_addr1;
  logic [DATA_WIDTH-1:0]   r_din0;

  logic [DATA_WIDTH-1:0]   r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   r_dout0, r_dout1;
  logic                    r_dvalid0, r_dvalid1;

  logic                    w_busy, w_in0, w_in1, w_rd0, w_wr0, w_rd1;
  logic [IDX_W-1:0]        w_idx0, w_idx1;
  logic [DATA_WIDTH-1:0]   w_word0, w_word1, w_merged, w_dout1_nxt;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_csb0   <= 1'b1;
      r_web0   <= 1'b1;
      r_csb1   <= 1'b1;
      r_wmask0 <= '0;
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_din0   <= '0;
    end else begin
      r_csb0   <= csb0;
      r_web0   <= web0;
      r_csb1   <= csb1;
      r_wmask0 <= wmask0;
      r_addr0  <= addr0;
      r_addr1  <= addr1;
      r_din0   <= din0;
    end
  end

  // Clear FSM state register.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StClear: begin
        w_cnt_nxt = r_cnt + IDX_W'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign w_busy = (r_state == StClear);
  assign busy   = w_busy;

  // Out-of-range addresses read as zero and never write.
  assign w_in0  = ({1'b0, r_addr0} < DEPTH_L);
  assign w_in1  = ({1'b0, r_addr1} < DEPTH_L);
  assign w_idx0 = r_addr0[IDX_W-1:0];
  assign w_idx1 = r_addr1[IDX_W-1:0];

  // Captured requests are squashed while the clear sequence owns the array.
  assign w_rd0 = !w_busy && !r_csb0 && r_web0;
  assign w_wr0 = !w_busy && !r_csb0 && !r_web0 && w_in0;
  assign w_rd1 = !w_busy && !r_csb1;

  assign w_word0 = w_in0 ? r_mem[w_idx0] : '0;
  assign w_word1 = w_in1 ? r_mem[w_idx1] : '0;

  always_comb begin
    w_merged = w_word0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (r_wmask0[b]) w_merged[b*8 +: 8] = r_din0[b*8 +: 8];
    end
  end

  // Write-first forwarding of the merged word on a same-address collision.
  assign w_dout1_nxt = ((RDW_MODE != 0) && w_wr0 && (r_addr0 == r_addr1)) ? w_merged : w_word1;

  // The array itself is never reset; only the clear sequence zeroes it.
  always_ff @(posedge clk0) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr0) begin
      r_mem[w_idx0] <= w_merged;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_dout0   <= '0;
      r_dout1   <= '0;
      r_dvalid0 <= 1'b0;
      r_dvalid1 <= 1'b0;
    end else begin
      r_dvalid0 <= w_rd0;
      r_dvalid1 <= w_rd1;
      if (w_rd0) r_dout0 <= w_word0;
      if (w_rd1) r_dout1 <= w_dout1_nxt;
    end
  end

  assign dout0   = r_dout0;
  assign dout1   = r_dout1;
  assign dvalid0 = r_dvalid0;
  assign dvalid1 = r_dvalid1;

endmodule

// File: tb/tb_cpu_mem_dp.sv
// Testbench for cpu_mem_dp. Two instances share one stimulus:
//   u_a: 8-bit words, 256 deep, read-first collisions
//   u_b: 32-bit words, 200 deep, write-first collisions
module tb_cpu_mem_dp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [7:0]  a_dout0, a_dout1;
  logic        a_dv0, a_dv1, a_busy;
  logic [31:0] b_dout0, b_dout1;
  logic        b_dv0, b_dv1, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_mem_dp #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .RAM_DEPTH(256), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_a (
    .clk0(clk), .rst0_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0[0:0]),
    .addr0(addr0), .din0(din0[7:0]), .dout0(a_dout0), .dvalid0(a_dv0),
    .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dvalid1(a_dv1), .busy(a_busy)
  );

  cpu_mem_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(200), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_b (
    .clk0(clk), .rst0_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .dvalid0(b_dv0),
    .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dvalid1(b_dv1), .busy(b_busy)
  );

  typedef struct {
    string       name;
    logic        c0, w0;
    logic [3:0]  m;
    logic [7:0]  a0;
    logic [31:0] d;
    logic        c1;
    logic [7:0]  a1;
    logic        e_dv0;
    logic [7:0]  e_ado0;
    logic [31:0] e_bdo0;
    logic        e_dv1;
    logic [7:0]  e_ado1;
    logic [31:0] e_bdo1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [3:0] m, input logic [7:0] a0,
                       input logic [31:0] d, input logic c1, input logic [7:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
  endtask

  task automatic chk_out(input string n, input logic dv0, input logic dv1, input logic [7:0] ado0,
                         input logic [31:0] bdo0, input logic [7:0] ado1, input logic [31:0] bdo1);
    chk($sformatf("%s a_dvalid0", n), {31'b0, a_dv0}, {31'b0, dv0});
    chk($sformatf("%s b_dvalid0", n), {31'b0, b_dv0}, {31'b0, dv0});
    chk($sformatf("%s a_dvalid1", n), {31'b0, a_dv1}, {31'b0, dv1});
    chk($sformatf("%s b_dvalid1", n), {31'b0, b_dv1}, {31'b0, dv1});
    chk($sformatf("%s a_dout0", n), {24'b0, a_dout0}, {24'b0, ado0});
    chk($sformatf("%s b_dout0", n), b_dout0, bdo0);
    chk($sformatf("%s a_dout1", n), {24'b0, a_dout1}, {24'b0, ado1});
    chk($sformatf("%s b_dout1", n), b_dout1, bdo1);
  endtask

  task automatic chk_no_dv(input string n);
    chk(n, {28'b0, a_dv0, a_dv1, b_dv0, b_dv1}, 32'h0);
  endtask

  task automatic add(input string n, input logic c0, input logic w0, input logic [3:0] m,
                     input logic [7:0] a0, input logic [31:0] d, input logic c1,
                     input logic [7:0] a1, input logic e0, input logic [7:0] ea0,
                     input logic [31:0] eb0, input logic e1, input logic [7:0] ea1,
                     input logic [31:0] eb1);
    vec_t v;
    v.name = n; v.c0 = c0; v.w0 = w0; v.m = m; v.a0 = a0; v.d = d; v.c1 = c1; v.a1 = a1;
    v.e_dv0 = e0; v.e_ado0 = ea0; v.e_bdo0 = eb0;
    v.e_dv1 = e1; v.e_ado1 = ea1; v.e_bdo1 = eb1;
    vecs.push_back(v);
  endtask

  // Drive at a negedge; request captured on the next posedge, serviced on the one after.
  task automatic apply(input vec_t v);
    drive(v.c0, v.w0, v.m, v.a0, v.d, v.c1, v.a1);
    @(negedge clk);
    chk_no_dv($sformatf("%s dvalid one edge early", v.name));
    idle();
    @(negedge clk);
    chk_out(v.name, v.e_dv0, v.e_dv1, v.e_ado0, v.e_bdo0, v.e_ado1, v.e_bdo1);
    @(negedge clk);
    chk_no_dv($sformatf("%s dvalid pulse end", v.name));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a_bcnt, b_bcnt, dvcnt;

    //   name                c0 w0 mask   a0     din           c1 a1     dv0 ado0  bdo0
    //                                                                   dv1 ado1  bdo1
    add("clr rd 0/255",      0, 1, 4'h0, 8'd0,   32'h0,        0, 8'd255,
        1, 8'h00, 32'h0, 1, 8'h00, 32'h0);
    add("clr rd 127/3",      0, 1, 4'h0, 8'd127, 32'h0,        0, 8'd3,
        1, 8'h00, 32'h0, 1, 8'h00, 32'h0);
    add("rd addr3",          0, 1, 4'h0, 8'd3,   32'h0,        1, 8'd0,
        1, 8'h00, 32'h0, 0, 8'h00, 32'h0);
    add("wr A5",             0, 0, 4'hF, 8'h10,  32'h000000A5, 1, 8'd0,
        0, 8'h00, 32'h0, 0, 8'h00, 32'h0);
    add("rd A5 latency",     0, 1, 4'h0, 8'h10,  32'h0,        1, 8'd0,
        1, 8'hA5, 32'h000000A5, 0, 8'h00, 32'h0);
    add("wr full word",      0, 0, 4'hF, 8'h20,  32'h11223344, 1, 8'd0,
        0, 8'hA5, 32'h000000A5, 0, 8'h00, 32'h0);
    add("wr mask 0101",      0, 0, 4'h5, 8'h20,  32'hAABBCCDD, 1, 8'd0,
        0, 8'hA5, 32'h000000A5, 0, 8'h00, 32'h0);
    add("rd both ports",     0, 1, 4'h0, 8'h20,  32'h0,        0, 8'h10,
        1, 8'hDD, 32'h11BB33DD, 1, 8'hA5, 32'h000000A5);
    add("wr mask 0000",      0, 0, 4'h0, 8'h20,  32'hFFFFFFFF, 1, 8'd0,
        0, 8'hDD, 32'h11BB33DD, 0, 8'hA5, 32'h000000A5);
    add("p1 rd after m0",    1, 1, 4'h0, 8'd0,   32'h0,        0, 8'h20,
        0, 8'hDD, 32'h11BB33DD, 1, 8'hDD, 32'h11BB33DD);
    add("collision",         0, 0, 4'hF, 8'h30,  32'h000000FF, 0, 8'h30,
        0, 8'hDD, 32'h11BB33DD, 1, 8'h00, 32'h000000FF);
    add("rd after coll",     1, 1, 4'h0, 8'd0,   32'h0,        0, 8'h30,
        0, 8'hDD, 32'h11BB33DD, 1, 8'hFF, 32'h000000FF);
    add("collision masked",  0, 0, 4'hA, 8'h20,  32'h55667788, 0, 8'h20,
        0, 8'hDD, 32'h11BB33DD, 1, 8'hDD, 32'h55BB77DD);
    add("rd masked coll",    0, 1, 4'h0, 8'h20,  32'h0,        1, 8'd0,
        1, 8'hDD, 32'h55BB77DD, 0, 8'hDD, 32'h55BB77DD);
    add("wr addr 250",       0, 0, 4'hF, 8'd250, 32'h00000055, 1, 8'd0,
        0, 8'hDD, 32'h55BB77DD, 0, 8'hDD, 32'h55BB77DD);
    add("rd 250 / 50",       0, 1, 4'h0, 8'd250, 32'h0,        0, 8'd50,
        1, 8'h55, 32'h0, 1, 8'h00, 32'h0);
    add("idle hold",         1, 1, 4'h0, 8'd0,   32'h0,        1, 8'd0,
        0, 8'h55, 32'h0, 0, 8'h00, 32'h0);

    idle();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("in reset", 1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 32'h0);
    chk("in reset a_busy", {31'b0, a_busy}, 32'h1);
    chk("in reset b_busy", {31'b0, b_busy}, 32'h1);

    // First clear: requests are ignored, then reset is pulsed at counter=100.
    rst_n = 1'b1;
    a_bcnt = 0; b_bcnt = 0; dvcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_busy) a_bcnt++;
      if (b_busy) b_bcnt++;
      if (a_dv0 || a_dv1 || b_dv0 || b_dv1) dvcnt++;
      if (i == 50)      drive(1'b0, 1'b0, 4'hF, 8'd3, 32'h77777777, 1'b1, 8'd0);
      else if (i == 60) drive(1'b0, 1'b1, 4'h0, 8'd3, 32'h0, 1'b0, 8'd3);
      else              idle();
      @(negedge clk);
    end
    chk("clear1 a_busy cycles", a_bcnt, 100);
    chk("clear1 b_busy cycles", b_bcnt, 100);
    chk("clear1 dvalid pulses", dvcnt, 0);

    rst_n = 1'b0;
    #1;
    chk("abort a_busy", {31'b0, a_busy}, 32'h1);
    chk("abort b_busy", {31'b0, b_busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Restarted clear; reads captured on the last two A-busy edges.
    a_bcnt = 0; b_bcnt = 0; dvcnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_busy) a_bcnt++;
      if (b_busy) b_bcnt++;
      if (a_dv0 || a_dv1) dvcnt++;
      if (i == 257) begin
        chk("enter-idle req a_dvalid0", {31'b0, a_dv0}, 32'h1);
        chk("enter-idle req a_dout0", {24'b0, a_dout0}, 32'h0);
      end
      if (i == 256) chk("b serviced at 256", {31'b0, b_dv0}, 32'h1);
      if (i == 150)                drive(1'b0, 1'b0, 4'hF, 8'd3, 32'h77777777, 1'b1, 8'd0);
      else if (i == 254 || i == 255) drive(1'b0, 1'b1, 4'h0, 8'd3, 32'h0, 1'b1, 8'd0);
      else                         idle();
      @(negedge clk);
    end
    chk("clear2 a_busy cycles", a_bcnt, 256);
    chk("clear2 b_busy cycles", b_bcnt, 200);
    chk("clear2 a dvalid pulses", dvcnt, 1);

    foreach (vecs[k]) apply(vecs[k]);

    // Back-to-back reads on both ports, one per cycle.
    drive(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h30);
    @(negedge clk);
    chk_no_dv("b2b early");
    drive(1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b0, 8'h10);
    @(negedge clk);
    chk_out("b2b req1", 1'b1, 1'b1, 8'hA5, 32'h000000A5, 8'hFF, 32'h000000FF);
    drive(1'b0, 1'b1, 4'h0, 8'h30, 32'h0, 1'b0, 8'h20);
    @(negedge clk);
    chk_out("b2b req2", 1'b1, 1'b1, 8'hDD, 32'h55BB77DD, 8'hA5, 32'h000000A5);
    idle();
    @(negedge clk);
    chk_out("b2b req3", 1'b1, 1'b1, 8'hFF, 32'h000000FF, 8'hDD, 32'h55BB77DD);
    @(negedge clk);
    chk_out("b2b end", 1'b0, 1'b0, 8'hFF, 32'h000000FF, 8'hDD, 32'h55BB77DD);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
